// File: rtl/saida_pkg.sv
// Shared types and constants for the 5-digit BCD output sequencer.
// Also holds the leading-zero blanking helper.
package saida_pkg;

  typedef enum logic [1:0] {StIdle, StShift, StLatch} estado_e;

  localparam int unsigned NUM_DIGITS  = 5;
  localparam logic [4:0]  BLANK_RESET = 5'b11110;

  // Bit k is set when digit k and every digit above it are zero; the units digit is never blanked.
  function automatic logic [4:0] calc_apaga(input logic [19:0] bcd);
    logic [4:0] mask;
    logic       zero;
    mask = '0;
    zero = 1'b1;
    for (int k = 4; k >= 1; k--) begin
      zero    = zero && (bcd[4*k +: 4] == 4'd0);
      mask[k] = zero;
    end
    return mask;
  endfunction

endpackage

// File: rtl/controle_saida_if.sv
// Print-request handshake and registered digit outputs between the core and the display path.
interface controle_saida_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  imprime;
  logic                  limpa;
  logic [DATA_WIDTH-1:0] data;
  logic                  pronto;
  logic                  atualizado;
  logic [3:0]            dezenaMilhar;
  logic [3:0]            unidadeMilhar;
  logic [3:0]            centena;
  logic [3:0]            dezena;
  logic [3:0]            unidade;
  logic [4:0]            apaga;

  modport master (
    output imprime, limpa, data,
    input  pronto, atualizado, dezenaMilhar, unidadeMilhar, centena, dezena, unidade, apaga
  );

  modport slave (
    input  imprime, limpa, data,
    output pronto, atualizado, dezenaMilhar, unidadeMilhar, centena, dezena, unidade, apaga
  );
endinterface

// File: rtl/corrige_bcd.sv
// Double-dabble correction cell: adds 3 to a BCD nibble that is 5 or more.
module corrige_bcd (
  input  logic [3:0] entrada,
  output logic [3:0] saida
);
  always_comb begin
    saida = entrada;
    if (entrada >= 4'd5) saida = entrada + 4'd3;
  end
endmodule

// File: rtl/controle_saida.sv
// Serial binary-to-BCD sequencer: one double-dabble step per clock, digits latched only
// once the conversion completes, plus leading-zero blank mask and update pulse.
module controle_saida
  import saida_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16
) (
  input logic              clk,
  input logic              rst_n,
  controle_saida_if.slave  bus
);

  localparam logic [4:0] LastCnt = 5'(DATA_WIDTH - 1);

  estado_e               state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [19:0]           bcd_q, bcd_d;
  logic [19:0]           bcd_corr;
  logic [4:0]            cnt_q, cnt_d;
  logic [19:0]           digits_q, digits_d;
  logic [4:0]            apaga_q, apaga_d;
  logic                  atual_q, atual_d;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_corr
    corrige_bcd u_corr (
      .entrada (bcd_q[4*g +: 4]),
      .saida   (bcd_corr[4*g +: 4])
    );
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    digits_d = digits_q;
    apaga_d  = apaga_q;
    atual_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.imprime) begin
          shift_d = bus.data;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        {bcd_d, shift_d} = {bcd_corr, shift_q} << 1;
        cnt_d            = cnt_q + 5'd1;
        if (cnt_q == LastCnt) state_d = StLatch;
      end
      StLatch: begin
        digits_d = bcd_q;
        apaga_d  = calc_apaga(bcd_q);
        atual_d  = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Clear wins over everything, including a simultaneous print request.
    if (bus.limpa) begin
      digits_d = '0;
      apaga_d  = BLANK_RESET;
      atual_d  = 1'b1;
      state_d  = StIdle;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      shift_q  <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      digits_q <= '0;
      apaga_q  <= BLANK_RESET;
      atual_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      digits_q <= digits_d;
      apaga_q  <= apaga_d;
      atual_q  <= atual_d;
    end
  end

  assign bus.pronto        = (state_q == StIdle);
  assign bus.atualizado    = atual_q;
  assign bus.dezenaMilhar  = digits_q[19:16];
  assign bus.unidadeMilhar = digits_q[15:12];
  assign bus.centena       = digits_q[11:8];
  assign bus.dezena        = digits_q[7:4];
  assign bus.unidade       = digits_q[3:0];
  assign bus.apaga         = apaga_q;

endmodule

// File: tb/tb_controle_saida.sv
// Directed bench for controle_saida: 16-bit and 8-bit builds, hand-computed BCD results.
module tb_controle_saida;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  controle_saida_if #(.DATA_WIDTH(16)) bus16 ();
  controle_saida_if #(.DATA_WIDTH(8))  bus8 ();

  controle_saida #(.DATA_WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
  controle_saida #(.DATA_WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

  logic [19:0] dig16, dig8;
  assign dig16 = {bus16.dezenaMilhar, bus16.unidadeMilhar, bus16.centena, bus16.dezena,
                  bus16.unidade};
  assign dig8  = {bus8.dezenaMilhar, bus8.unidadeMilhar, bus8.centena, bus8.dezena,
                  bus8.unidade};

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bus16.imprime = 1'b0; bus16.limpa = 1'b0; bus16.data = '0;
    bus8.imprime  = 1'b0; bus8.limpa  = 1'b0; bus8.data  = '0;

    #12;
    check("rst_digits", dig16, 20'h00000);
    check("rst_apaga", bus16.apaga, 5'b11110);
    check("rst_pronto", bus16.pronto, 1'b1);
    check("rst_atual", bus16.atualizado, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);

    // 12345: 17-edge latency, pronto low throughout, no partial values shown
    bus16.data = 16'd12345; bus16.imprime = 1'b1;
    tick(1);
    bus16.imprime = 1'b0;
    check("t2_pronto_e0", bus16.pronto, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      tick(1);
      check("t2_pronto_busy", bus16.pronto, 1'b0);
      check("t2_atual_busy", bus16.atualizado, 1'b0);
      check("t2_digits_hold", dig16, 20'h00000);
    end
    tick(1);
    check("t2_atual", bus16.atualizado, 1'b1);
    check("t2_pronto", bus16.pronto, 1'b1);
    check("t2_digits", dig16, 20'h12345);
    check("t2_apaga", bus16.apaga, 5'b00000);
    tick(1);
    check("t2_atual_pulse", bus16.atualizado, 1'b0);

    // 65535 then 0 back to back with imprime held
    bus16.data = 16'd65535; bus16.imprime = 1'b1;
    tick(1);
    bus16.data = 16'd0;
    tick(16);
    check("t3_atual_early", bus16.atualizado, 1'b0);
    tick(1);
    check("t3_digits_a", dig16, 20'h65535);
    check("t3_apaga_a", bus16.apaga, 5'b00000);
    check("t3_atual_a", bus16.atualizado, 1'b1);
    check("t3_pronto_a", bus16.pronto, 1'b1);
    tick(1);
    bus16.imprime = 1'b0;
    check("t3_accept_b", bus16.pronto, 1'b0);
    check("t3_hold_a", dig16, 20'h65535);
    tick(16);
    check("t3_atual_b_early", bus16.atualizado, 1'b0);
    tick(1);
    check("t3_digits_b", dig16, 20'h00000);
    check("t3_apaga_b", bus16.apaga, 5'b11110);
    check("t3_atual_b", bus16.atualizado, 1'b1);

    // 42, with an ignored request during SHIFT
    bus16.data = 16'd42; bus16.imprime = 1'b1;
    tick(1);
    bus16.imprime = 1'b0;
    tick(3);
    bus16.data = 16'd7; bus16.imprime = 1'b1;
    tick(1);
    bus16.imprime = 1'b0;
    tick(12);
    tick(1);
    check("t4_digits", dig16, 20'h00042);
    check("t4_apaga", bus16.apaga, 5'b11100);
    check("t4_atual", bus16.atualizado, 1'b1);
    tick(3);
    check("t4_digits_hold", dig16, 20'h00042);
    check("t4_pronto_idle", bus16.pronto, 1'b1);
    check("t4_atual_quiet", bus16.atualizado, 1'b0);

    // limpa with imprime, 5 cycles into 999
    bus16.data = 16'd999; bus16.imprime = 1'b1;
    tick(1);
    bus16.imprime = 1'b0;
    tick(5);
    bus16.limpa = 1'b1; bus16.imprime = 1'b1;
    tick(1);
    bus16.limpa = 1'b0; bus16.imprime = 1'b0;
    check("t5_digits", dig16, 20'h00000);
    check("t5_apaga", bus16.apaga, 5'b11110);
    check("t5_pronto", bus16.pronto, 1'b1);
    check("t5_atual", bus16.atualizado, 1'b1);
    tick(20);
    check("t5_no_999", dig16, 20'h00000);
    check("t5_atual_quiet", bus16.atualizado, 1'b0);
    // limpa must beat imprime in IDLE too
    bus16.data = 16'd5; bus16.limpa = 1'b1; bus16.imprime = 1'b1;
    tick(1);
    bus16.limpa = 1'b0; bus16.imprime = 1'b0;
    check("t5_idle_prio", bus16.pronto, 1'b1);

    // Reset mid-conversion after a visible result
    bus16.data = 16'd12345; bus16.imprime = 1'b1;
    tick(1);
    bus16.imprime = 1'b0;
    tick(17);
    check("t1_pre_digits", dig16, 20'h12345);
    bus16.data = 16'd999; bus16.imprime = 1'b1;
    tick(1);
    bus16.imprime = 1'b0;
    tick(4);
    #2 rst_n = 1'b0;
    #1;
    check("t1_digits", dig16, 20'h00000);
    check("t1_apaga", bus16.apaga, 5'b11110);
    check("t1_pronto", bus16.pronto, 1'b1);
    check("t1_atual", bus16.atualizado, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(20);
    check("t1_after_digits", dig16, 20'h00000);
    check("t1_after_pronto", bus16.pronto, 1'b1);

    // 8-bit build: 255 after 9 edges
    bus8.data = 8'd255; bus8.imprime = 1'b1;
    tick(1);
    bus8.imprime = 1'b0;
    check("t6_pronto_busy", bus8.pronto, 1'b0);
    tick(8);
    check("t6_atual_early", bus8.atualizado, 1'b0);
    check("t6_digits_hold", dig8, 20'h00000);
    tick(1);
    check("t6_digits", dig8, 20'h00255);
    check("t6_apaga", bus8.apaga, 5'b11000);
    check("t6_atual", bus8.atualizado, 1'b1);
    check("t6_pronto", bus8.pronto, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
